// File: rtl/vga_timing_generator.sv
// ---------------------------------------------------------------------------
// vga_timing_generator
//
// Produces 640x480@60 VGA timing from a 25 MHz pixel clock. It drives the
// pixel address to the GPU controller and takes back that controller's
// colour. The colour then leaves as registered, blanked VGA pins that stay
// aligned with the syncs.
//
// Ports:
//   clk            pixel clock (25 MHz)
//   rst_n          asynchronous active-low reset, released synchronously
//   pixel_data     RGB332 colour for the current address, {R[7:5],G[4:2],B[1:0]}
//   address        {pixel_y[9:0], pixel_x[9:0]}, forced to 0 outside the
//                  visible area
//   h_sync         horizontal sync, active low, registered
//   v_sync         vertical sync, active low, registered
//   display_enable high while the output colour is a visible pixel
//   frame_start    one-cycle pulse coinciding with output of pixel (0,0)
//   vga_red        3-bit red, registered
//   vga_green      3-bit green, registered
//   vga_blue       2-bit blue, registered
// ---------------------------------------------------------------------------
module vga_timing_generator #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pixel_data,
    output logic [19:0] address,
    output logic        h_sync,
    output logic        v_sync,
    output logic        display_enable,
    output logic        frame_start,
    output logic [2:0]  vga_red,
    output logic [2:0]  vga_green,
    output logic [1:0]  vga_blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // 10-bit copies of the timing boundaries so every compare is width-matched
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END   = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG  = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_SYNC_END  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG  = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_SYNC_END  = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    // Timing bundle order is {frame_start, active, hs, vs}. The inactive
    // value keeps both syncs high so that reset never emits a sync pulse.
    localparam logic [3:0] TIMING_IDLE = 4'b0011;

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       active;
    logic       hs_raw;
    logic       vs_raw;
    logic       fs_raw;
    logic [3:0] timing_raw;
    logic [3:0] timing_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count <= 10'd0;
            v_count <= 10'd0;
        end else if (h_count == H_LAST) begin
            h_count <= 10'd0;
            v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count <= h_count + 10'd1;
        end
    end

    assign active = (h_count < H_ACT_END) && (v_count < V_ACT_END);
    assign hs_raw = !((h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END));
    assign vs_raw = !((v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END));
    assign fs_raw = (h_count == 10'd0) && (v_count == 10'd0);

    // Blanked addresses fall back to 0 so the memories always see a legal index
    assign address = active ? {v_count, h_count} : 20'h0_0000;

    assign timing_raw = {fs_raw, active, hs_raw, vs_raw};

    // The timing bundle is delayed to match the latency of the colour source,
    // so the colour arriving at pixel_data meets the timing of its own address.
    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign timing_dly = timing_raw;
        end else begin : g_delay
            logic [3:0] stage [PIPE_DELAY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        stage[i] <= TIMING_IDLE;
                    end
                end else begin
                    stage[0] <= timing_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign timing_dly = stage[PIPE_DELAY-1];
        end
    endgenerate

    // Final output stage. Syncs, enable and colour all load on the same edge.
    // The colour is forced to 0 whenever the delayed timing is outside the
    // visible area.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start    <= 1'b0;
            display_enable <= 1'b0;
            h_sync         <= 1'b1;
            v_sync         <= 1'b1;
            vga_red        <= 3'd0;
            vga_green      <= 3'd0;
            vga_blue       <= 2'd0;
        end else begin
            frame_start    <= timing_dly[3];
            display_enable <= timing_dly[2];
            h_sync         <= timing_dly[1];
            v_sync         <= timing_dly[0];
            if (timing_dly[2]) begin
                vga_red   <= pixel_data[7:5];
                vga_green <= pixel_data[4:2];
                vga_blue  <= pixel_data[1:0];
            end else begin
                vga_red   <= 3'd0;
                vga_green <= 3'd0;
                vga_blue  <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_generator
//
// This bench drives three instances from one clock and one reset:
//   full  - default 640x480 geometry, PIPE_DELAY=0, colour held at 8'hFF
//   small - reduced geometry 16/4/8/4 x 12/2/2/3 (32 x 19 totals),
//           PIPE_DELAY=0, colour held at 8'hFF
//   pipe  - the same reduced geometry with PIPE_DELAY=2. Its colour is the
//           low byte of its address from two cycles earlier.
// The reduced geometry makes whole frames short enough to run twice.
// ---------------------------------------------------------------------------
module tb_vga_timing_generator;

    logic clk;
    logic rst_n;
    logic [7:0] pixel_ff;

    logic [19:0] addr_full, addr_small, addr_pipe;
    logic hs_full, vs_full, de_full, fs_full;
    logic hs_small, vs_small, de_small, fs_small;
    logic hs_pipe, vs_pipe, de_pipe, fs_pipe;
    logic [2:0] r_full, g_full, r_small, g_small, r_pipe, g_pipe;
    logic [1:0] b_full, b_small, b_pipe;

    logic [7:0] pd_d1, pd_d2;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_idx = 0;

    int full_hs_low_cnt;
    int small_vs_low_cnt;
    int full_fs_cnt;
    int full_hs_fall[$];
    int small_hs_fall[$];
    int pipe_hs_fall[$];
    int small_vs_fall[$];
    int small_fs_edges[$];
    logic prev_hs_full, prev_hs_small, prev_hs_pipe, prev_vs_small;

    vga_timing_generator dut_full (
        .clk(clk), .rst_n(rst_n), .pixel_data(pixel_ff), .address(addr_full),
        .h_sync(hs_full), .v_sync(vs_full), .display_enable(de_full),
        .frame_start(fs_full), .vga_red(r_full), .vga_green(g_full), .vga_blue(b_full)
    );

    vga_timing_generator #(
        .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(0)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .pixel_data(pixel_ff), .address(addr_small),
        .h_sync(hs_small), .v_sync(vs_small), .display_enable(de_small),
        .frame_start(fs_small), .vga_red(r_small), .vga_green(g_small), .vga_blue(b_small)
    );

    vga_timing_generator #(
        .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(2)
    ) dut_pipe (
        .clk(clk), .rst_n(rst_n), .pixel_data(pd_d2), .address(addr_pipe),
        .h_sync(hs_pipe), .v_sync(vs_pipe), .display_enable(de_pipe),
        .frame_start(fs_pipe), .vga_red(r_pipe), .vga_green(g_pipe), .vga_blue(b_pipe)
    );

    // 25 MHz pixel clock
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Memory with two cycles of read latency that feeds the pipelined instance
    always @(posedge clk) begin
        pd_d1 <= addr_pipe[7:0];
        pd_d2 <= pd_d1;
    end

    // Expected {frame_start, display_enable, h_sync, v_sync, r, g, b} after
    // rising edge e following reset release
    function automatic logic [11:0] model(input int e, input int delay,
                                          input int ha, input int hf, input int hsw, input int hb,
                                          input int va, input int vf, input int vsw, input int vb,
                                          input bit ramp);
        int s, ht, vt, h, v;
        logic act, hs, vs, fs;
        logic [7:0] px;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (e < delay + 1) return 12'h300;
        s  = e - delay - 1;
        h  = s % ht;
        v  = (s / ht) % vt;
        act = (h < ha) && (v < va);
        hs  = !((h >= ha + hf) && (h < ha + hf + hsw));
        vs  = !((v >= va + vf) && (v < va + vf + vsw));
        fs  = (h == 0) && (v == 0);
        px  = ramp ? 8'(h) : 8'hFF;
        return {fs, act, hs, vs, (act ? px : 8'h00)};
    endfunction

    // Expected address while the counters are in state e
    function automatic logic [19:0] addr_model(input int e, input int ha, input int ht,
                                               input int va, input int vt);
        int h, v;
        h = e % ht;
        v = (e / ht) % vt;
        if ((h < ha) && (v < va)) return {10'(v), 10'(h)};
        return 20'h0;
    endfunction

    task automatic checkOutput(input string tag, input logic [19:0] observed,
                               input logic [19:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearStats();
        full_hs_low_cnt  = 0;
        small_vs_low_cnt = 0;
        full_fs_cnt      = 0;
        full_hs_fall.delete();
        small_hs_fall.delete();
        pipe_hs_fall.delete();
        small_vs_fall.delete();
        small_fs_edges.delete();
        prev_hs_full  = 1'b1;
        prev_hs_small = 1'b1;
        prev_hs_pipe  = 1'b1;
        prev_vs_small = 1'b1;
    endtask

    // Advance n rising edges. After each edge, sample on the falling edge,
    // compare every instance with the model and record sync and frame events.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            edge_idx++;
            @(negedge clk);
            checkOutput($sformatf("full_out@%0d", edge_idx),
                        {8'h0, fs_full, de_full, hs_full, vs_full, r_full, g_full, b_full},
                        {8'h0, model(edge_idx, 0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)});
            checkOutput($sformatf("small_out@%0d", edge_idx),
                        {8'h0, fs_small, de_small, hs_small, vs_small, r_small, g_small, b_small},
                        {8'h0, model(edge_idx, 0, 16, 4, 8, 4, 12, 2, 2, 3, 1'b0)});
            checkOutput($sformatf("pipe_out@%0d", edge_idx),
                        {8'h0, fs_pipe, de_pipe, hs_pipe, vs_pipe, r_pipe, g_pipe, b_pipe},
                        {8'h0, model(edge_idx, 2, 16, 4, 8, 4, 12, 2, 2, 3, 1'b1)});
            checkOutput($sformatf("full_addr@%0d", edge_idx), addr_full,
                        addr_model(edge_idx, 640, 800, 480, 525));
            checkOutput($sformatf("small_addr@%0d", edge_idx), addr_small,
                        addr_model(edge_idx, 16, 32, 12, 19));

            if (edge_idx <= 800 && !hs_full) full_hs_low_cnt++;
            if (edge_idx <= 608 && !vs_small) small_vs_low_cnt++;
            if (fs_full) full_fs_cnt++;
            if (fs_small) small_fs_edges.push_back(edge_idx);
            if (prev_hs_full && !hs_full) full_hs_fall.push_back(edge_idx);
            if (prev_hs_small && !hs_small) small_hs_fall.push_back(edge_idx);
            if (prev_hs_pipe && !hs_pipe) pipe_hs_fall.push_back(edge_idx);
            if (prev_vs_small && !vs_small) small_vs_fall.push_back(edge_idx);
            prev_hs_full  = hs_full;
            prev_hs_small = hs_small;
            prev_hs_pipe  = hs_pipe;
            prev_vs_small = vs_small;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        pixel_ff = 8'hFF;
        clearStats();
        $display("[TB] start");

        repeat (3) @(negedge clk);
        checkOutput("reset_full_out",
                    {8'h0, fs_full, de_full, hs_full, vs_full, r_full, g_full, b_full}, 20'h00300);
        checkOutput("reset_pipe_out",
                    {8'h0, fs_pipe, de_pipe, hs_pipe, vs_pipe, r_pipe, g_pipe, b_pipe}, 20'h00300);
        checkOutput("reset_full_addr", addr_full, 20'h0);

        // Release between edges so the next rising edge is the first active one
        rst_n    = 1'b1;
        edge_idx = 0;

        applyStimulus(3);
        checkOutput("pipe_first_fs", {19'h0, fs_pipe}, 20'h1);
        checkOutput("pipe_first_de", {19'h0, de_pipe}, 20'h1);
        checkOutput("pipe_rgb_px0", {12'h0, r_pipe, g_pipe, b_pipe}, 20'h00000);
        applyStimulus(1);
        checkOutput("pipe_rgb_px1", {12'h0, r_pipe, g_pipe, b_pipe}, 20'h00001);

        applyStimulus(363);
        checkOutput("small_addr_last_px", addr_small, 20'h02C0F);
        applyStimulus(1);
        checkOutput("small_addr_blank", addr_small, 20'h0);

        applyStimulus(271);
        checkOutput("full_addr_x639", addr_full, 20'h0027F);
        applyStimulus(1);
        checkOutput("full_addr_x640", addr_full, 20'h0);

        applyStimulus(1060);
        checkOutput("full_hs_first_fall", 20'(full_hs_fall.size() > 0 ? full_hs_fall[0] : -1), 20'd657);
        checkOutput("full_hs_period",
                    20'(full_hs_fall.size() > 1 ? full_hs_fall[1] - full_hs_fall[0] : -1), 20'd800);
        checkOutput("full_hs_width", 20'(full_hs_low_cnt), 20'd96);
        checkOutput("full_fs_count", 20'(full_fs_cnt), 20'd1);
        checkOutput("small_hs_first_fall", 20'(small_hs_fall.size() > 0 ? small_hs_fall[0] : -1), 20'd21);
        checkOutput("pipe_hs_first_fall", 20'(pipe_hs_fall.size() > 0 ? pipe_hs_fall[0] : -1), 20'd23);
        checkOutput("small_vs_width", 20'(small_vs_low_cnt), 20'd64);
        checkOutput("small_vs_first_fall", 20'(small_vs_fall.size() > 0 ? small_vs_fall[0] : -1), 20'd449);
        checkOutput("small_vs_period",
                    20'(small_vs_fall.size() > 1 ? small_vs_fall[1] - small_vs_fall[0] : -1), 20'd608);
        checkOutput("small_fs_count", 20'(small_fs_edges.size()), 20'd3);
        checkOutput("small_fs_second", 20'(small_fs_edges.size() > 1 ? small_fs_edges[1] : -1), 20'd609);

        // Reset mid-frame: small is at line 5 inside h-sync, and full is
        // mid-visible on line 2
        applyStimulus(306);
        checkOutput("pre_reset_small_hs", {19'h0, hs_small}, 20'h0);
        checkOutput("pre_reset_full_de", {19'h0, de_full}, 20'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_full_out",
                    {8'h0, fs_full, de_full, hs_full, vs_full, r_full, g_full, b_full}, 20'h00300);
        checkOutput("async_small_out",
                    {8'h0, fs_small, de_small, hs_small, vs_small, r_small, g_small, b_small}, 20'h00300);
        checkOutput("async_full_addr", addr_full, 20'h0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("hold_syncs_%0d", k),
                        {14'h0, hs_full, vs_full, hs_small, vs_small, hs_pipe, vs_pipe}, 20'h0003F);
        end

        rst_n    = 1'b1;
        edge_idx = 0;
        clearStats();
        applyStimulus(1);
        checkOutput("rerun_small_fs", {19'h0, fs_small}, 20'h1);
        checkOutput("rerun_full_fs", {19'h0, fs_full}, 20'h1);
        applyStimulus(700);
        checkOutput("rerun_small_fs_second",
                    20'(small_fs_edges.size() > 1 ? small_fs_edges[1] : -1), 20'd609);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
